path_direction_encoder: RTL and testbench
=========================================

Name: path_direction_encoder

Overview:
- Inverse of the grid neighbour generator: takes a stream of linear node indices forming a path on a width×height grid and emits one direction code per consecutive pair (prev→cur).
- Direction encoding matches the neighbour generator: 0 = +width (row+1), 1 = +1 (col+1), 2 = −width (row−1), 3 = −1 (col−1); 4 = same node; 15 = not a neighbour / out of grid.
- Sits after path back-tracking (fed from priority-queue search results), before the move/command serialiser.

Parameters:
- IW, 16, index/width/height bit width
- DW, 4, direction code width

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous active-low reset
- width_i  in  IW  grid width x; static while a path is in flight
- height_i  in  IW  grid height y; static while a path is in flight
- in_valid_i  in  1  index beat valid
- in_idx_i  in  IW  node index
- in_last_i  in  1  final index of path
- in_ready_o  out  1  index accepted when valid&ready
- out_valid_o  out  1  direction beat valid
- out_dir_o  out  DW  direction code
- out_err_o  out  1  pair was not a legal neighbour step
- out_last_o  out  1  beat belongs to final index of path
- out_ready_i  in  1  downstream accept

Behaviour:
- Reset (async, rstn=0): state=S_IDLE; in_ready_o=0 during reset, 1 after; out_valid_o=0, out_dir_o=0, out_err_o=0, out_last_o=0; prev/row/col regs=0. Reset mid-divide or mid-path discards everything.
- States: S_IDLE (await first index), S_DIV (restoring divide), S_CHK (1 cycle range check), S_RUN (stream pairs).
- S_IDLE: in_ready_o=1 iff out slot free (!out_valid_o | out_ready_i). On accept: prev←idx, last_pend←in_last_i, div counter←0, goto S_DIV.
- S_DIV: restoring divide of prev by width_i, one quotient bit per cycle, 16 cycles (counter 0..15); row←quotient, col←remainder. in_ready_o=0.
- S_CHK: illegal if width_i==0 or row≥height_i. Illegal: load error beat (dir=15, err=1, last=last_pend), goto S_IDLE. Legal and last_pend: load beat dir=4, err=0, last=1 (single-node path), goto S_IDLE. Legal otherwise: goto S_RUN, no beat.
- First-index latency: accept at cycle t, in_ready_o high again at t+18 (16 DIV + 1 CHK + 1 RUN entry).
- S_RUN: in_ready_o = !out_valid_o | out_ready_i. On accept of cur (next cycle, registered output):
  - cur==prev → dir 4
  - cur==prev+width & row+1<height → dir 0, row+1
  - cur==prev+1 & col+1<width → dir 1, col+1
  - cur==prev−width & row≥1 → dir 2, row−1
  - cur==prev−1 & col≥1 → dir 3, col−1
  - else → dir 15, err=1
  - Additions/subtractions IW-bit, compared with carry/borrow excluded (prev+width overflow is never a match; prev<width never matches −width).
  - prev←cur. Legal: row/col updated incrementally, stay in S_RUN. Error: re-derive row/col, goto S_DIV (next in_ready_o after 18 cycles).
  - in_last_i: beat carries out_last_o=1, goto S_IDLE (a legal-step error with last goes to S_IDLE directly, no divide).
- Output slot: single register; held stable while out_valid_o & !out_ready_i; cleared on out_ready_i when no new load. Simultaneous drain and load in one cycle allowed (full throughput in S_RUN: 1 beat/cycle).
- in_valid_i ignored whenever in_ready_o=0.

Test Plan:
- width=4,height=3; path 5,6,10,9,5(last) with out_ready=1 → beats dir 1,0,3,2; last only on 4th; first in_ready re-assert 18 cycles after accepting 5; then 1 beat/cycle.
- Row wrap: path 7,8(last) → one beat dir=15, err=1, last=1; path 7,3,4 → dir 2 then err 15, then in_ready low 18 cycles, then 4→5 gives dir 1.
- Out of grid: first index 12 (row 3≥3) → error beat dir=15, last as given, back to S_IDLE; width_i=0 → same error.
- Single-node path: index 0 with last=1 → one beat dir=4, err=0, last=1.
- Backpressure: out_ready=0 for 5 cycles mid-path → in_ready_o=0, out_dir_o held; release → no beat lost/duplicated.
- Assert rstn low at DIV cycle 7 → all outputs 0 immediately; after release, new path 1,0 → dir 3.

Source files
------------

// File: rtl/path_direction_encoder.sv
// Turns a stream of linear grid indices into per-step direction codes (0:+row 1:+col 2:-row 3:-col 4:same 15:bad).
// A path's first index (and any index after a bad step) is split into row/col by a 16-cycle restoring divide.
module path_direction_encoder #(
  parameter int IW = 16,
  parameter int DW = 4
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic [IW-1:0] width_i,
  input  logic [IW-1:0] height_i,
  input  logic          in_valid_i,
  input  logic [IW-1:0] in_idx_i,
  input  logic          in_last_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_dir_o,
  output logic          out_err_o,
  output logic          out_last_o,
  input  logic          out_ready_i
);

  localparam int CW = $clog2(IW);
  localparam logic [DW-1:0] DIR_DOWN  = DW'(0);
  localparam logic [DW-1:0] DIR_RIGHT = DW'(1);
  localparam logic [DW-1:0] DIR_UP    = DW'(2);
  localparam logic [DW-1:0] DIR_LEFT  = DW'(3);
  localparam logic [DW-1:0] DIR_SAME  = DW'(4);
  localparam logic [DW-1:0] DIR_BAD   = DW'(15);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CHK, S_RUN} state_t;

  state_t        state;
  logic [IW-1:0] prev;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic [CW-1:0] divCnt;
  logic          lastPend;
  logic          readyEn;

  logic slotFree;
  logic accept;
  assign slotFree   = !out_valid_o || out_ready_i;
  assign in_ready_o = readyEn && slotFree && (state == S_IDLE || state == S_RUN);
  assign accept     = in_valid_i && in_ready_o;

  // During the divide, row holds the shifting dividend/quotient and col the partial remainder.
  logic [IW:0]   remShift;
  logic          remGe;
  logic [IW-1:0] remSub;
  assign remShift = {col, row[IW-1]};
  assign remGe    = remShift >= {1'b0, width_i};
  assign remSub   = IW'(remShift - {1'b0, width_i});

  // Top bit of each sum/difference is carry/borrow; a wrapped result never counts as a neighbour.
  logic [IW:0] plusW, plusOne, minusW, minusOne, rowInc, colInc;
  assign plusW    = {1'b0, prev} + {1'b0, width_i};
  assign plusOne  = {1'b0, prev} + (IW+1)'(1);
  assign minusW   = {1'b0, prev} - {1'b0, width_i};
  assign minusOne = {1'b0, prev} - (IW+1)'(1);
  assign rowInc   = {1'b0, row} + (IW+1)'(1);
  assign colInc   = {1'b0, col} + (IW+1)'(1);

  logic [DW-1:0] stepDir;
  logic          stepErr;
  logic [IW-1:0] nextRow;
  logic [IW-1:0] nextCol;

  always_comb begin
    stepDir = DIR_BAD;
    stepErr = 1'b1;
    nextRow = row;
    nextCol = col;
    if (in_idx_i == prev) begin
      stepDir = DIR_SAME;
      stepErr = 1'b0;
    end else if (!plusW[IW] && in_idx_i == plusW[IW-1:0] && rowInc < {1'b0, height_i}) begin
      stepDir = DIR_DOWN;
      stepErr = 1'b0;
      nextRow = rowInc[IW-1:0];
    end else if (!plusOne[IW] && in_idx_i == plusOne[IW-1:0] && colInc < {1'b0, width_i}) begin
      stepDir = DIR_RIGHT;
      stepErr = 1'b0;
      nextCol = colInc[IW-1:0];
    end else if (!minusW[IW] && in_idx_i == minusW[IW-1:0] && row != '0) begin
      stepDir = DIR_UP;
      stepErr = 1'b0;
      nextRow = row - IW'(1);
    end else if (!minusOne[IW] && in_idx_i == minusOne[IW-1:0] && col != '0) begin
      stepDir = DIR_LEFT;
      stepErr = 1'b0;
      nextCol = col - IW'(1);
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state       <= S_IDLE;
      prev        <= '0;
      row         <= '0;
      col         <= '0;
      divCnt      <= '0;
      lastPend    <= 1'b0;
      readyEn     <= 1'b0;
      out_valid_o <= 1'b0;
      out_dir_o   <= '0;
      out_err_o   <= 1'b0;
      out_last_o  <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      // Drain first; a load later in this block takes precedence in the same cycle.
      if (out_ready_i) begin
        out_valid_o <= 1'b0;
        out_dir_o   <= '0;
        out_err_o   <= 1'b0;
        out_last_o  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            prev     <= in_idx_i;
            row      <= in_idx_i;
            col      <= '0;
            lastPend <= in_last_i;
            divCnt   <= '0;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          col    <= remGe ? remSub : remShift[IW-1:0];
          row    <= {row[IW-2:0], remGe};
          divCnt <= divCnt + CW'(1);
          if (divCnt == CW'(IW-1)) state <= S_CHK;
        end
        S_CHK: begin
          // Wait for a free slot so a pending beat is never overwritten.
          if (slotFree) begin
            if (width_i == '0 || row >= height_i) begin
              out_valid_o <= 1'b1;
              out_dir_o   <= DIR_BAD;
              out_err_o   <= 1'b1;
              out_last_o  <= lastPend;
              state       <= S_IDLE;
            end else if (lastPend) begin
              out_valid_o <= 1'b1;
              out_dir_o   <= DIR_SAME;
              out_err_o   <= 1'b0;
              out_last_o  <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            out_valid_o <= 1'b1;
            out_dir_o   <= stepDir;
            out_err_o   <= stepErr;
            out_last_o  <= in_last_i;
            prev        <= in_idx_i;
            if (in_last_i) begin
              state <= S_IDLE;
            end else if (stepErr) begin
              row      <= in_idx_i;
              col      <= '0;
              lastPend <= 1'b0;
              divCnt   <= '0;
              state    <= S_DIV;
            end else begin
              row <= nextRow;
              col <= nextCol;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_direction_encoder.sv
// Directed and randomized paths scored against a coordinate-based reference model.
module tb_path_direction_encoder;
  localparam int IW = 16;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [IW-1:0] width = 16'd4;
  logic [IW-1:0] height = 16'd3;
  logic          inValid = 1'b0;
  logic [IW-1:0] inIdx = '0;
  logic          inLast = 1'b0;
  logic          inReady;
  logic          outValid;
  logic [DW-1:0] outDir;
  logic          outErr;
  logic          outLast;
  logic          outReady = 1'b1;

  path_direction_encoder #(.IW(IW), .DW(DW)) dut (
    .system1000(clk), .system1000_rstn(rstn),
    .width_i(width), .height_i(height),
    .in_valid_i(inValid), .in_idx_i(inIdx), .in_last_i(inLast), .in_ready_o(inReady),
    .out_valid_o(outValid), .out_dir_o(outDir), .out_err_o(outErr), .out_last_o(outLast),
    .out_ready_i(outReady)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: positions are handled as (row, col) coordinates.
  typedef struct {int dir; bit err; bit last;} beat_t;
  beat_t expQ[$];
  bit    mInPath = 1'b0;
  int    mPrev = 0;

  function automatic void mStart(input int idx, input bit last);
    int w = int'(width);
    int h = int'(height);
    if (w == 0 || idx / w >= h) begin
      expQ.push_back('{15, 1'b1, last});
      mInPath = 1'b0;
    end else if (last) begin
      expQ.push_back('{4, 1'b0, 1'b1});
      mInPath = 1'b0;
    end else begin
      mInPath = 1'b1;
      mPrev = idx;
    end
  endfunction

  function automatic void mStep(input int cur, input bit last);
    int w = int'(width);
    int h = int'(height);
    int pr = mPrev / w, pc = mPrev % w, cr = cur / w, cc = cur % w;
    bit inGrid = longint'(cur) < longint'(w) * longint'(h);
    int dir = 15;
    if (cur == mPrev) dir = 4;
    else if (inGrid && cr == pr + 1 && cc == pc) dir = 0;
    else if (inGrid && cr == pr && cc == pc + 1) dir = 1;
    else if (inGrid && cr == pr - 1 && cc == pc) dir = 2;
    else if (inGrid && cr == pr && cc == pc - 1) dir = 3;
    expQ.push_back('{dir, dir == 15, last});
    if (dir == 15) begin
      if (last) mInPath = 1'b0;
      else mStart(cur, 1'b0);
    end else begin
      mPrev = cur;
      if (last) mInPath = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rstn) begin
      expQ.delete();
      mInPath = 1'b0;
    end else begin
      if (outValid && outReady) begin
        checkVal("beat_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkVal("dir", outDir, e.dir);
          checkVal("err", outErr, e.err);
          checkVal("last", outLast, e.last);
        end
      end
      if (inValid && inReady) begin
        if (mInPath) mStep(int'(inIdx), inLast);
        else mStart(int'(inIdx), inLast);
      end
    end
  end

  bit randRdy = 1'b0;
  bit forceRdy = 1'b1;
  always @(posedge clk) begin
    #1;
    outReady = randRdy ? ($urandom_range(0, 3) != 0) : forceRdy;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic sendIdx(input int idx, input bit last, output int waits);
    inValid = 1'b1;
    inIdx = IW'(idx);
    inLast = last;
    waits = 0;
    @(negedge clk);
    while (!inReady && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (!inReady) checkVal("accept_timeout", inReady, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkVal("drain_timeout", expQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waits, w, h, cur, nxt, len, r;
    // Reset values
    #23;
    checkVal("rst_out_valid", outValid, 0);
    checkVal("rst_out_dir", outDir, 0);
    checkVal("rst_out_err", outErr, 0);
    checkVal("rst_out_last", outLast, 0);
    checkVal("rst_in_ready", inReady, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checkVal("ready_after_reset", inReady, 1);

    // Basic path with first-index latency and full throughput
    sendIdx(5, 1'b0, waits);
    sendIdx(6, 1'b0, waits);
    checkVal("first_ready_gap", waits + 1, 18);
    sendIdx(10, 1'b0, waits);
    checkVal("throughput_10", waits, 0);
    sendIdx(9, 1'b0, waits);
    checkVal("throughput_9", waits, 0);
    sendIdx(5, 1'b1, waits);
    checkVal("throughput_5", waits, 0);
    drain();

    // Row wrap errors
    sendIdx(7, 1'b0, waits);
    sendIdx(8, 1'b1, waits);
    drain();
    sendIdx(7, 1'b0, waits);
    sendIdx(3, 1'b0, waits);
    sendIdx(4, 1'b0, waits);
    sendIdx(5, 1'b1, waits);
    checkVal("err_rederive_gap", waits + 1, 18);
    drain();

    // Out of grid and zero width
    sendIdx(12, 1'b0, waits);
    drain();
    width = 16'd0;
    sendIdx(3, 1'b1, waits);
    drain();
    width = 16'd4;

    // Single-node path
    sendIdx(0, 1'b1, waits);
    drain();

    // Backpressure mid-path
    sendIdx(0, 1'b0, waits);
    sendIdx(1, 1'b0, waits);
    forceRdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    inValid = 1'b1; inIdx = 16'd2; inLast = 1'b0;
    @(negedge clk);
    checkVal("bp_accept", inReady, 1);
    @(posedge clk); #1;
    inIdx = 16'd6; inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("bp_in_ready", inReady, 0);
      checkVal("bp_valid_held", outValid, 1);
      checkVal("bp_dir_held", outDir, 1);
    end
    @(posedge clk); #1;
    forceRdy = 1'b1;
    sendIdx(6, 1'b1, waits);
    drain();

    // Carry out of prev+width never matches
    width = 16'hFFF0; height = 16'd2;
    sendIdx(20, 1'b0, waits);
    sendIdx(4, 1'b1, waits);
    drain();
    sendIdx(5, 1'b0, waits);
    sendIdx(16'hFFF5, 1'b1, waits);
    drain();
    width = 16'd4; height = 16'd3;

    // Reset in the middle of the divide
    sendIdx(5, 1'b0, waits);
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checkVal("midrst_valid", outValid, 0);
    checkVal("midrst_dir", outDir, 0);
    checkVal("midrst_in_ready", inReady, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    sendIdx(1, 1'b0, waits);
    sendIdx(0, 1'b1, waits);
    drain();

    // Randomized paths with random backpressure
    randRdy = 1'b1;
    for (int p = 0; p < 150; p++) begin
      drain();
      w = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
      h = int'($urandom_range(1, 5));
      width = IW'(w);
      height = IW'(h);
      len = int'($urandom_range(1, 8));
      cur = int'($urandom_range(0, w * h + 2));
      for (int k = 0; k < len; k++) begin
        r = int'($urandom_range(0, 2));
        if (r != 0) begin
          repeat (r) @(posedge clk);
          #1;
        end
        sendIdx(cur, k == len - 1, waits);
        r = int'($urandom_range(0, 9));
        if (w == 0 || r >= 8) nxt = int'($urandom_range(0, w * h + 3));
        else begin
          case (r % 5)
            0: nxt = cur + w;
            1: nxt = cur + 1;
            2: nxt = cur - w;
            3: nxt = cur - 1;
            default: nxt = cur;
          endcase
        end
        if (nxt < 0) nxt = 0;
        if (nxt > 65535) nxt = 65535;
        cur = nxt;
      end
    end
    drain();
    randRdy = 1'b0;

    checkVal("leftover_beats", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
